// File: rtl/ysyx_idu_if.sv
// Fetch-to-decode-to-execute handshake and decoded bundle of the ysyx decode stage.
// The slave side is the decode unit; the master side drives fetch inputs and consumes the bundle.
interface ysyx_idu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              prev_valid;
  logic              ready_o;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] pc;
  logic              flush;
  logic              valid_o;
  logic              next_ready;
  logic [ADDR_W-1:0] pc_o;
  logic [DATA_W-1:0] inst_o;
  logic [6:0]        opcode_o;
  logic [2:0]        funct3_o;
  logic              funct7b5_o;
  logic [4:0]        rd_o;
  logic [4:0]        rs1_o;
  logic [4:0]        rs2_o;
  logic              rs1_en_o;
  logic              rs2_en_o;
  logic              wen_o;
  logic [31:0]       imm_o;
  logic              illegal_o;

  modport master (
    output prev_valid, inst, pc, flush, next_ready,
    input  ready_o, valid_o, pc_o, inst_o, opcode_o, funct3_o, funct7b5_o,
           rd_o, rs1_o, rs2_o, rs1_en_o, rs2_en_o, wen_o, imm_o, illegal_o
  );

  modport slave (
    input  prev_valid, inst, pc, flush, next_ready,
    output ready_o, valid_o, pc_o, inst_o, opcode_o, funct3_o, funct7b5_o,
           rd_o, rs1_o, rs2_o, rs1_en_o, rs2_en_o, wen_o, imm_o, illegal_o
  );
endinterface

// File: rtl/ysyx_idu.sv
// RV32I decode stage: a single-entry pipeline register holding one fetched instruction,
// with every decoded field derived from the registered word so inst never reaches the outputs combinationally.
module ysyx_idu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic       clk,
  input logic       rst,
  ysyx_idu_if.slave bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic              w_ready;
  logic              w_accept;
  logic              w_valid;
  logic [DATA_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       w_inst32;
  logic [6:0]        w_op;
  logic              w_opKnown;
  logic              w_legal;
  logic              w_rs1Use;
  logic              w_rs2Use;
  logic              w_wrUse;
  logic [31:0]       w_imm;

  assign w_valid  = (r_state == FULL);
  assign w_ready  = !w_valid || bus.next_ready;
  assign w_accept = bus.prev_valid && w_ready && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Flush wins over everything; a simultaneous drain and accept keeps the stage FULL.
  always_comb begin
    w_nextState = r_state;
    if (bus.flush) begin
      w_nextState = EMPTY;
    end else if (w_accept) begin
      w_nextState = FULL;
    end else if (bus.next_ready) begin
      w_nextState = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst <= '0;
      r_pc   <= '0;
    end else if (w_accept) begin
      r_inst <= bus.inst;
      r_pc   <= bus.pc;
    end
  end

  assign w_inst32 = r_inst[31:0];
  assign w_op     = w_inst32[6:0];

  always_comb begin
    w_opKnown = 1'b1;
    w_rs1Use  = 1'b0;
    w_rs2Use  = 1'b0;
    w_wrUse   = 1'b0;
    w_imm     = 32'h0;
    case (w_op)
      7'h03, 7'h13, 7'h67, 7'h73: begin
        w_imm    = {{20{w_inst32[31]}}, w_inst32[31:20]};
        w_rs1Use = 1'b1;
        w_wrUse  = 1'b1;
      end
      7'h0F: begin
        w_opKnown = 1'b1;
      end
      7'h17, 7'h37: begin
        w_imm   = {w_inst32[31:12], 12'h000};
        w_wrUse = 1'b1;
      end
      7'h23: begin
        w_imm    = {{20{w_inst32[31]}}, w_inst32[31:25], w_inst32[11:7]};
        w_rs1Use = 1'b1;
        w_rs2Use = 1'b1;
      end
      7'h33: begin
        w_rs1Use = 1'b1;
        w_rs2Use = 1'b1;
        w_wrUse  = 1'b1;
      end
      7'h63: begin
        w_imm    = {{19{w_inst32[31]}}, w_inst32[31], w_inst32[7],
                    w_inst32[30:25], w_inst32[11:8], 1'b0};
        w_rs1Use = 1'b1;
        w_rs2Use = 1'b1;
      end
      7'h6F: begin
        w_imm   = {{11{w_inst32[31]}}, w_inst32[31], w_inst32[19:12],
                   w_inst32[20], w_inst32[30:21], 1'b0};
        w_wrUse = 1'b1;
      end
      default: begin
        w_opKnown = 1'b0;
      end
    endcase
  end

  assign w_legal = w_opKnown && (w_inst32[1:0] == 2'b11);

  // Control fields are qualified by valid so an empty stage never looks like it issues anything.
  assign bus.ready_o    = w_ready;
  assign bus.valid_o    = w_valid;
  assign bus.pc_o       = r_pc;
  assign bus.inst_o     = r_inst;
  assign bus.opcode_o   = w_op;
  assign bus.funct3_o   = w_inst32[14:12];
  assign bus.funct7b5_o = w_inst32[30];
  assign bus.rd_o       = w_inst32[11:7];
  assign bus.rs1_o      = w_inst32[19:15];
  assign bus.rs2_o      = w_inst32[24:20];
  assign bus.imm_o      = w_imm;
  assign bus.rs1_en_o   = w_valid && w_legal && w_rs1Use;
  assign bus.rs2_en_o   = w_valid && w_legal && w_rs2Use;
  assign bus.wen_o      = w_valid && w_legal && w_wrUse && (w_inst32[11:7] != 5'd0);
  assign bus.illegal_o  = w_valid && !w_legal;

endmodule
